// File: rtl/mems_pkg.sv
// Shared definitions for the MEMS scan sequencer: FSM state codes, phase
// encoding, default widths and default scan geometry.
package mems_pkg;

   localparam int DEF_ADDR_W       = 16;
   localparam int DEF_DATA_W       = 24;
   localparam int DEF_INIT_CMDS    = 2;
   localparam int DEF_SCAN_BASE    = 8;
   localparam int DEF_FRAME_POINTS = 12800;
   localparam int DEF_LINE_LEN     = 320;
   localparam int DEF_LINE_OFFSET  = 80;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_FETCH = 2'd1;
   localparam state_t ST_ISSUE = 2'd2;
   localparam state_t ST_GAP   = 2'd3;

   localparam logic PH_INIT = 1'b0;
   localparam logic PH_SCAN = 1'b1;

   // Points between consecutive line markers: a full line, or half a line
   // when markers are wanted on both the up and the down sweep.
   function automatic int segLen(input int lineLen, input logic bidir);
      return bidir ? (lineLen / 2) : lineLen;
   endfunction

endpackage

// File: rtl/mems_scan_sequencer_if.sv
// Bundle of the sequencer's SPI, ROM, marker and control signals.
// master = sequencer side, slave = environment side.
interface mems_scan_sequencer_if
   import mems_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              soft_reset_req;
   logic              pause;
   logic              bidir_mode;
   logic              spi_busy;
   logic              spi_start;
   logic [DATA_W-1:0] spi_data;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              new_line;
   logic              new_line_ack;
   logic              new_frame;
   logic              new_frame_ack;
   logic              marker_overrun;
   logic [15:0]       frame_count;
   logic              scanning;

   modport master (
      input  soft_reset_req, pause, bidir_mode, spi_busy, rom_data,
             new_line_ack, new_frame_ack,
      output spi_start, spi_data, rom_addr, new_line, new_frame,
             marker_overrun, frame_count, scanning
   );

   modport slave (
      output soft_reset_req, pause, bidir_mode, spi_busy, rom_data,
             new_line_ack, new_frame_ack,
      input  spi_start, spi_data, rom_addr, new_line, new_frame,
             marker_overrun, frame_count, scanning
   );

endinterface

// File: rtl/mems_marker_gen.sv
// Line/frame marker generator. Tracks the scan index within a frame and a
// segment down-counter, raises sticky new_frame/new_line flags with ack
// handshakes, and flags an overrun when a marker lands on a pending flag.
module mems_marker_gen
   import mems_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int LINE_LEN    = DEF_LINE_LEN,
   parameter int LINE_OFFSET = DEF_LINE_OFFSET
)(
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_issue,
   input  logic i_frameStart,
   input  logic i_bidir,
   input  logic i_lineAck,
   input  logic i_frameAck,
   output logic o_newLine,
   output logic o_newFrame,
   output logic o_overrun
);

   localparam logic [ADDR_W-1:0] OFFSET_IDX = ADDR_W'(LINE_OFFSET);

   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_segCnt;
   logic              r_pastOffset;
   logic              r_bidir;
   logic              r_newLine;
   logic              r_newFrame;
   logic              r_overrun;

   logic [ADDR_W-1:0] w_segLast;
   logic              w_setFrame;
   logic              w_setLine;

   assign w_segLast  = ADDR_W'(segLen(LINE_LEN, r_bidir) - 1);
   assign w_setFrame = i_issue && (r_idx == OFFSET_IDX);
   assign w_setLine  = i_issue && r_pastOffset && (r_segCnt == '0);

   // Scan index and segment countdown; bidir choice is latched per frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx        <= '0;
         r_segCnt     <= '0;
         r_pastOffset <= 1'b0;
         r_bidir      <= 1'b0;
      end else if (i_clear) begin
         r_idx        <= '0;
         r_segCnt     <= '0;
         r_pastOffset <= 1'b0;
         r_bidir      <= 1'b0;
      end else if (i_frameStart) begin
         r_idx        <= '0;
         r_segCnt     <= '0;
         r_pastOffset <= 1'b0;
         r_bidir      <= i_bidir;
      end else if (i_issue) begin
         r_idx <= r_idx + ADDR_W'(1);
         if (w_setFrame) begin
            r_pastOffset <= 1'b1;
            r_segCnt     <= w_segLast;
         end else if (r_pastOffset) begin
            r_segCnt <= (r_segCnt == '0) ? w_segLast : (r_segCnt - ADDR_W'(1));
         end
      end
   end

   // Sticky flags: set beats ack, and a set onto a pending flag is an overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_newLine  <= 1'b0;
         r_newFrame <= 1'b0;
         r_overrun  <= 1'b0;
      end else if (i_clear) begin
         r_newLine  <= 1'b0;
         r_newFrame <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_setLine) begin
            r_newLine <= 1'b1;
         end else if (i_lineAck) begin
            r_newLine <= 1'b0;
         end
         if (w_setFrame) begin
            r_newFrame <= 1'b1;
         end else if (i_frameAck) begin
            r_newFrame <= 1'b0;
         end
         if ((w_setLine && r_newLine) || (w_setFrame && r_newFrame)) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign o_newLine  = r_newLine;
   assign o_newFrame = r_newFrame;
   assign o_overrun  = r_overrun;

endmodule

// File: rtl/mems_scan_sequencer.sv
// MEMS scan sequencer top: issues the DAC init block then streams scan
// points from ROM over the SPI master, frame after frame, and drives the
// line/frame markers for the capture path.
module mems_scan_sequencer
   import mems_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int INIT_CMDS    = DEF_INIT_CMDS,
   parameter int SCAN_BASE    = DEF_SCAN_BASE,
   parameter int FRAME_POINTS = DEF_FRAME_POINTS,
   parameter int LINE_LEN     = DEF_LINE_LEN,
   parameter int LINE_OFFSET  = DEF_LINE_OFFSET
)(
   input logic                   clk,
   input logic                   rst_n,
   mems_scan_sequencer_if.master bus
);

   localparam logic [ADDR_W-1:0] LAST_INIT_ADDR = ADDR_W'(INIT_CMDS - 1);
   localparam logic [ADDR_W-1:0] SCAN_BASE_ADDR = ADDR_W'(SCAN_BASE);
   localparam logic [ADDR_W-1:0] LAST_SCAN_ADDR = ADDR_W'(SCAN_BASE + FRAME_POINTS - 1);

   state_t            r_state;
   logic              r_phase;
   logic [ADDR_W-1:0] r_romAddr;
   logic [DATA_W-1:0] r_spiData;
   logic              r_spiStart;
   logic [15:0]       r_frameCount;
   logic              r_scanning;

   logic w_fire;
   logic w_advance;
   logic w_lastInit;
   logic w_lastScan;
   logic w_frameStart;
   logic w_frameWrap;
   logic w_scanIssue;
   logic w_newLine;
   logic w_newFrame;
   logic w_overrun;

   // A soft reset in the ISSUE cycle suppresses the start; pause only gates scan points.
   assign w_fire       = (r_state == ST_ISSUE) && !bus.soft_reset_req && !bus.spi_busy &&
                         ((r_phase == PH_INIT) || !bus.pause);
   assign w_advance    = (r_state == ST_GAP) && !bus.soft_reset_req;
   assign w_lastInit   = (r_romAddr == LAST_INIT_ADDR);
   assign w_lastScan   = (r_romAddr == LAST_SCAN_ADDR);
   assign w_frameWrap  = w_advance && (r_phase == PH_SCAN) && w_lastScan;
   assign w_frameStart = w_frameWrap || (w_advance && (r_phase == PH_INIT) && w_lastInit);
   assign w_scanIssue  = w_fire && (r_phase == PH_SCAN);

   // Command FSM: fetch ROM word, issue it when the SPI master is free, then
   // a gap cycle before moving to the next address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_phase      <= PH_INIT;
         r_romAddr    <= '0;
         r_spiData    <= '0;
         r_spiStart   <= 1'b0;
         r_frameCount <= '0;
         r_scanning   <= 1'b0;
      end else if (bus.soft_reset_req) begin
         r_state      <= ST_FETCH;
         r_phase      <= PH_INIT;
         r_romAddr    <= '0;
         r_spiStart   <= 1'b0;
         r_frameCount <= '0;
         r_scanning   <= 1'b0;
      end else begin
         r_spiStart <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_IDLE;
            end
            ST_FETCH: begin
               r_state <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (w_fire) begin
                  r_spiData  <= bus.rom_data;
                  r_spiStart <= 1'b1;
                  r_state    <= ST_GAP;
               end
            end
            ST_GAP: begin
               r_state <= ST_FETCH;
               if (r_phase == PH_INIT) begin
                  if (w_lastInit) begin
                     r_romAddr  <= SCAN_BASE_ADDR;
                     r_phase    <= PH_SCAN;
                     r_scanning <= 1'b1;
                  end else begin
                     r_romAddr <= r_romAddr + ADDR_W'(1);
                  end
               end else begin
                  if (w_lastScan) begin
                     r_romAddr    <= SCAN_BASE_ADDR;
                     r_frameCount <= r_frameCount + 16'd1;
                  end else begin
                     r_romAddr <= r_romAddr + ADDR_W'(1);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   mems_marker_gen #(
      .ADDR_W      (ADDR_W),
      .LINE_LEN    (LINE_LEN),
      .LINE_OFFSET (LINE_OFFSET)
   ) u_markerGen (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (bus.soft_reset_req),
      .i_issue      (w_scanIssue),
      .i_frameStart (w_frameStart),
      .i_bidir      (bus.bidir_mode),
      .i_lineAck    (bus.new_line_ack),
      .i_frameAck   (bus.new_frame_ack),
      .o_newLine    (w_newLine),
      .o_newFrame   (w_newFrame),
      .o_overrun    (w_overrun)
   );

   assign bus.spi_start      = r_spiStart;
   assign bus.spi_data       = r_spiData;
   assign bus.rom_addr       = r_romAddr;
   assign bus.new_line       = w_newLine;
   assign bus.new_frame      = w_newFrame;
   assign bus.marker_overrun = w_overrun;
   assign bus.frame_count    = r_frameCount;
   assign bus.scanning       = r_scanning;

endmodule

// File: tb/tb_mems_scan_sequencer.sv
// Directed bench for mems_scan_sequencer with a small geometry and ROM[a]=a.
module tb_mems_scan_sequencer;

   localparam int ADDR_W       = 16;
   localparam int DATA_W       = 24;
   localparam int INIT_CMDS    = 2;
   localparam int SCAN_BASE    = 4;
   localparam int FRAME_POINTS = 32;
   localparam int LINE_LEN     = 8;
   localparam int LINE_OFFSET  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int checks     = 0;
   int errors     = 0;
   int cycleCount = 0;
   int lastStart  = 0;
   bit skipGap    = 1'b1;
   int startCount = 0;

   bit mLine  = 1'b0;
   bit mFrame = 1'b0;
   bit mOv    = 1'b0;

   mems_scan_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mems_scan_sequencer #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .INIT_CMDS    (INIT_CMDS),
      .SCAN_BASE    (SCAN_BASE),
      .FRAME_POINTS (FRAME_POINTS),
      .LINE_LEN     (LINE_LEN),
      .LINE_OFFSET  (LINE_OFFSET)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Synchronous ROM holding its own address; cycle counter for spacing checks
   always @(posedge clk) begin
      cycleCount   <= cycleCount + 1;
      bus.rom_data <= DATA_W'(bus.rom_addr);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic iPause, input logic iBidir, input logic iBusy);
      bus.pause      = iPause;
      bus.bidir_mode = iBidir;
      bus.spi_busy   = iBusy;
   endtask

   // Waits (bounded) for the next spi_start, checking issue spacing
   task automatic waitStart();
      bit seen;
      int n;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.spi_start === 1'b1) seen = 1'b1;
      end
      checkOutput("startSeen", 32'(seen), 32'd1);
      if (seen) begin
         if (!skipGap) checkOutput("issueGap", 32'(cycleCount - lastStart), 32'd3);
         lastStart = cycleCount;
         skipGap   = 1'b0;
      end
   endtask

   // One expected command issue at ROM address addr, with marker model
   task automatic checkIssue(input int addr, input int seg, input int fc, input bit autoAck);
      int idx;
      bit setF;
      bit setL;
      waitStart();
      checkOutput($sformatf("spiData@%0d", addr), 32'(bus.spi_data), 32'(addr));
      if (addr >= SCAN_BASE) begin
         idx  = addr - SCAN_BASE;
         setF = (idx == LINE_OFFSET);
         setL = (idx > LINE_OFFSET) && (((idx - LINE_OFFSET) % seg) == 0);
         if ((setF && mFrame) || (setL && mLine)) mOv = 1'b1;
         if (setF) mFrame = 1'b1;
         if (setL) mLine = 1'b1;
         checkOutput($sformatf("newFrame@%0d", addr), 32'(bus.new_frame), 32'(mFrame));
         checkOutput($sformatf("newLine@%0d", addr), 32'(bus.new_line), 32'(mLine));
         checkOutput($sformatf("overrun@%0d", addr), 32'(bus.marker_overrun), 32'(mOv));
         checkOutput($sformatf("scanning@%0d", addr), 32'(bus.scanning), 32'd1);
         if (addr == SCAN_BASE)
            checkOutput("frameCount", 32'(bus.frame_count), 32'(fc));
      end else begin
         checkOutput($sformatf("scanningInit@%0d", addr), 32'(bus.scanning), 32'd0);
      end
      if (autoAck && (mLine || mFrame)) begin
         bus.new_line_ack  = mLine;
         bus.new_frame_ack = mFrame;
         @(negedge clk);
         bus.new_line_ack  = 1'b0;
         bus.new_frame_ack = 1'b0;
         mLine  = 1'b0;
         mFrame = 1'b0;
      end
   endtask

   task automatic scanRange(input int fromA, input int toA, input int seg, input int fc,
                            input bit autoAck);
      for (int a = fromA; a <= toA; a++) checkIssue(a, seg, fc, autoAck);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".spiStart"}, 32'(bus.spi_start), 32'd0);
      checkOutput({tag, ".spiData"}, 32'(bus.spi_data), 32'd0);
      checkOutput({tag, ".romAddr"}, 32'(bus.rom_addr), 32'd0);
      checkOutput({tag, ".newLine"}, 32'(bus.new_line), 32'd0);
      checkOutput({tag, ".newFrame"}, 32'(bus.new_frame), 32'd0);
      checkOutput({tag, ".overrun"}, 32'(bus.marker_overrun), 32'd0);
      checkOutput({tag, ".frameCount"}, 32'(bus.frame_count), 32'd0);
      checkOutput({tag, ".scanning"}, 32'(bus.scanning), 32'd0);
   endtask

   initial begin
      bus.soft_reset_req = 1'b0;
      bus.new_line_ack   = 1'b0;
      bus.new_frame_ack  = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Reset state, then idle until the soft reset request
      rst_n = 1'b0;
      #23;
      checkAllZero("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkAllZero("idle");

      // Init block with pause held high: pause must not stall init
      applyStimulus(1'b1, 1'b0, 1'b0);
      bus.soft_reset_req = 1'b1;
      @(negedge clk);
      bus.soft_reset_req = 1'b0;
      skipGap = 1'b1;
      checkIssue(0, LINE_LEN, 0, 1'b1);
      checkIssue(1, LINE_LEN, 0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Frame 0, unidirectional, with a busy stall after address 11
      scanRange(4, 11, LINE_LEN, 0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      startCount = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.spi_start === 1'b1) startCount++;
      end
      checkOutput("busyNoStart", 32'(startCount), 32'd0);
      checkOutput("busyAddrFrozen", 32'(bus.rom_addr), 32'd12);
      applyStimulus(1'b0, 1'b0, 1'b0);
      skipGap = 1'b1;
      scanRange(12, 35, LINE_LEN, 0, 1'b1);

      // Frame 1: bidir raised mid-frame must not change this frame; pause stall
      scanRange(4, 13, LINE_LEN, 1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      startCount = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.spi_start === 1'b1) startCount++;
      end
      checkOutput("pauseNoStart", 32'(startCount), 32'd0);
      checkOutput("pauseAddrFrozen", 32'(bus.rom_addr), 32'd14);
      applyStimulus(1'b0, 1'b1, 1'b0);
      skipGap = 1'b1;
      scanRange(14, 35, LINE_LEN, 1, 1'b1);

      // Frame 2: bidir markers; dropping bidir mid-frame waits for the wrap
      scanRange(4, 19, LINE_LEN / 2, 2, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      scanRange(20, 35, LINE_LEN / 2, 2, 1'b1);

      // Frame 3: unacked line markers cause overrun; ack on the set cycle
      scanRange(4, 13, LINE_LEN, 3, 1'b1);
      scanRange(14, 22, LINE_LEN, 3, 1'b0);
      bus.new_line_ack = 1'b1;
      @(negedge clk);
      bus.new_line_ack = 1'b0;
      mLine = 1'b0;
      checkOutput("lineClearedByAck", 32'(bus.new_line), 32'd0);
      checkOutput("overrunSticky", 32'(bus.marker_overrun), 32'd1);
      scanRange(23, 29, LINE_LEN, 3, 1'b1);
      repeat (2) @(negedge clk);
      bus.new_line_ack = 1'b1;
      checkIssue(30, LINE_LEN, 3, 1'b0);
      bus.new_line_ack = 1'b0;
      @(negedge clk);
      checkOutput("lineHeldAfterSameCycleAck", 32'(bus.new_line), 32'd1);
      bus.new_line_ack = 1'b1;
      @(negedge clk);
      bus.new_line_ack = 1'b0;
      mLine = 1'b0;
      scanRange(31, 35, LINE_LEN, 3, 1'b1);

      // Frame 4: leave flags pending, then soft reset at address 20
      scanRange(4, 20, LINE_LEN, 4, 1'b0);
      bus.soft_reset_req = 1'b1;
      @(negedge clk);
      bus.soft_reset_req = 1'b0;
      mLine  = 1'b0;
      mFrame = 1'b0;
      mOv    = 1'b0;
      checkOutput("softRst.spiStart", 32'(bus.spi_start), 32'd0);
      checkOutput("softRst.newLine", 32'(bus.new_line), 32'd0);
      checkOutput("softRst.newFrame", 32'(bus.new_frame), 32'd0);
      checkOutput("softRst.overrun", 32'(bus.marker_overrun), 32'd0);
      checkOutput("softRst.frameCount", 32'(bus.frame_count), 32'd0);
      checkOutput("softRst.scanning", 32'(bus.scanning), 32'd0);
      skipGap = 1'b1;
      checkIssue(0, LINE_LEN, 0, 1'b1);
      checkIssue(1, LINE_LEN, 0, 1'b1);
      scanRange(4, 5, LINE_LEN, 0, 1'b1);

      // Asynchronous reset in the middle of the GAP cycle
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("asyncRst");
      #10;
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
